refresh_sequencer: RTL and testbench
====================================

# refresh_sequencer

Periodic DRAM refresh controller for the LiteDRAM bank-machine array. It counts tREFI intervals and broadcasts `refresh_req` to every bank machine. Once all bank machines grant (rows closed, tWTP satisfied), it issues PRECHARGE-ALL and then AUTO-REFRESH on its own command stream, honouring tRP and tRFC. That command stream is one requester into the command multiplexer, alongside the bank machines.

## Interface
Parameters:
- `NBANKS`, 8, number of bank machines whose `refresh_gnt` is collected
- `A_WIDTH`, 14, command address width
- `BA_WIDTH`, 3, bank address width
- `TREFI`, 782, refresh interval in sys_clk cycles (≥ 2)
- `TRP`, 3, precharge-to-refresh wait in cycles (≥ 1)
- `TRFC`, 30, refresh-to-release wait in cycles (≥ 1)
- `TZQCS`, 16, ZQ short-calibration wait in cycles; used only with `REFRESH_ZQCS_EN`

Ports:
- `sys_clk` in 1: system clock, all logic on its rising edge
- `sys_rst` in 1: reset, asynchronous, active-high
- `enable` in 1: interval timer runs only while high
- `refresh_req` out 1: registered request, broadcast to all bank machines
- `refresh_gnt` in NBANKS: per-bank grant
- `cmd_valid` out 1: command strobe
- `cmd_ready` in 1: command accept from the multiplexer
- `cmd_payload_a` out A_WIDTH: command address
- `cmd_payload_ba` out BA_WIDTH: bank address, constant 0
- `cmd_payload_cas`, `cmd_payload_ras`, `cmd_payload_we` out 1 each: command encoding, active-high
- `cmd_payload_is_cmd` out 1: high whenever `cmd_valid` is high
- `cmd_payload_is_read`, `cmd_payload_is_write` out 1 each: constant 0
- `busy` out 1: state ≠ IDLE
- `missed` out 1: sticky flag, a tREFI expiry occurred while a refresh was already pending

## Operation
- Interval timer:
  - Load TREFI−1 on reset.
  - While `enable` is high, decrement. At 0, set `pending` and reload TREFI−1.
  - While `enable` is low, the timer holds its value.
- If the timer expires while `pending` is still set, set `missed`. Only `sys_rst` clears `missed`. `pending` does not accumulate.
- States and transitions:
  - IDLE: if `pending`, go to WAIT_GNT and clear `pending`.
  - WAIT_GNT: `refresh_req` = 1. Go to PRE when `refresh_gnt` is all ones.
  - PRE: `cmd_valid` = 1, with ras=1, we=1, cas=0, a[10]=1, other address bits 0. On `cmd_valid & cmd_ready`, load the wait counter with TRP−1 and go to WAIT_TRP.
  - WAIT_TRP: decrement the wait counter. At 0, go to REF.
  - REF: `cmd_valid` = 1, with ras=1, cas=1, we=0, a=0. On handshake, load TRFC−1 and go to WAIT_TRFC.
  - WAIT_TRFC: decrement. At 0, go to ZQ if `REFRESH_ZQCS_EN` is defined, otherwise to IDLE.
  - ZQ (with macro only): `cmd_valid` = 1, with we=1, ras=0, cas=0, a=0. On handshake, load TZQCS−1 and go to WAIT_ZQ.
  - WAIT_ZQ: decrement. At 0, go to IDLE.
- `refresh_req` is registered. It is set on the clock edge entering WAIT_GNT and cleared on the edge entering IDLE. It stays high through PRE, the REF/ZQ commands and all waits.
- `cmd_valid` and the payload are combinational decodes of the state. The payload is stable while `cmd_valid` is high and `cmd_ready` is low, and is all zeros when `cmd_valid` is low.
- A grant that drops mid-sequence after WAIT_GNT is ignored.
- A timer expiry during the sequence sets `pending`, so the next refresh starts right after the return to IDLE.
- `enable` low does not abort a sequence already in progress.

## Timing
- Reset values:
  - state IDLE; `pending` = 0; `missed` = 0; timer = TREFI−1; wait counter = 0.
  - All outputs 0.
- Interval: with `enable` continuously high from reset release, `pending` sets on the TREFI-th rising edge. WAIT_GNT is entered one edge later, so `refresh_req` is first high in cycle TREFI+1.
- Grant: if all grants are high in the first WAIT_GNT cycle, PRE asserts `cmd_valid` on the next cycle.
- Gaps:
  - From PRE handshake to REF `cmd_valid`: exactly TRP cycles in WAIT_TRP.
  - From REF handshake to the IDLE transition: exactly TRFC cycles.
- Back-pressure: `cmd_ready` low holds PRE/REF/ZQ indefinitely with the payload unchanged.
- Asynchronous `sys_rst` mid-sequence: immediately forces IDLE, drops `refresh_req` and `cmd_valid`, and reloads the timer.

## Configuration
- `REFRESH_ZQCS_EN` defined:
  - ZQ and WAIT_ZQ are present; each refresh ends with a ZQCS command followed by a TZQCS wait.
  - `refresh_req` is held through WAIT_ZQ.
- `REFRESH_ZQCS_EN` undefined:
  - ZQ and WAIT_ZQ are absent and TZQCS is unused.
  - WAIT_TRFC exits directly to IDLE.

## Test plan
- Basic sequence. Stimulus: TREFI=20, TRP=3, TRFC=5; `enable`=1; `cmd_ready`=1; grants tied high. Response: `refresh_req` rises in cycle 21; PRE (ras=1, we=1, a=0x400) in cycle 22; REF (ras=1, cas=1) in cycle 26; `refresh_req` low in cycle 32; repeats every 20 cycles.
- Grant gating. Stimulus: drive grants with bank 5 low for 10 cycles after `refresh_req` rises. Response: no `cmd_valid` until the cycle after all 8 grants are high.
- Back-pressure. Stimulus: hold `cmd_ready`=0 for 7 cycles during PRE. Response: `cmd_valid`=1 and the payload unchanged for 8 cycles; the tRP gap is counted from the handshake.
- Overrun. Stimulus: keep grants low for 45 cycles with TREFI=20. Response: `missed` becomes 1 and stays 1; a single pending refresh runs once the grants arrive.
- Reset mid-operation. Stimulus: assert `sys_rst` during WAIT_TRFC. Response: `refresh_req`, `cmd_valid` and `busy` drop without waiting for a clock; after release, the first request occurs TREFI+1 cycles later.
- `REFRESH_ZQCS_EN` build. Stimulus: TZQCS=4, otherwise as the basic sequence. Response: ZQCS (we=1 only) appears exactly 5 cycles after the REF handshake; `refresh_req` drops 4 cycles after the ZQ handshake.

Source files
------------

// File: rtl/refresh_sequencer.sv
// refresh_sequencer: tREFI interval timer plus grant-gated PRECHARGE-ALL / AUTO-REFRESH command stream.
// Defining REFRESH_ZQCS_EN appends a ZQCS short calibration (and tZQCS wait) to every refresh.
module refresh_sequencer #(
    parameter int NBANKS   = 8,
    parameter int A_WIDTH  = 14,
    parameter int BA_WIDTH = 3,
    parameter int TREFI    = 782,
    parameter int TRP      = 3,
    parameter int TRFC     = 30,
    parameter int TZQCS    = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                enable,
    output logic                refresh_req,
    input  logic [NBANKS-1:0]   refresh_gnt,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic [A_WIDTH-1:0]  cmd_payload_a,
    output logic [BA_WIDTH-1:0] cmd_payload_ba,
    output logic                cmd_payload_cas,
    output logic                cmd_payload_ras,
    output logic                cmd_payload_we,
    output logic                cmd_payload_is_cmd,
    output logic                cmd_payload_is_read,
    output logic                cmd_payload_is_write,
    output logic                busy,
    output logic                missed
);
    localparam int TW    = $clog2(TREFI);
    localparam int WMAX0 = (TRP > TRFC) ? TRP : TRFC;
    localparam int WMAX  = (WMAX0 > TZQCS) ? WMAX0 : TZQCS;
    localparam int WW    = (WMAX > 1) ? $clog2(WMAX) : 1;
    localparam logic [A_WIDTH-1:0] A_PRE_ALL = A_WIDTH'(1) << 10;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_GNT  = 3'd1,
        S_PRE       = 3'd2,
        S_WAIT_TRP  = 3'd3,
        S_REF       = 3'd4,
        S_WAIT_TRFC = 3'd5
`ifdef REFRESH_ZQCS_EN
        , S_ZQ      = 3'd6,
        S_WAIT_ZQ   = 3'd7
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            pending_q, pending_d;
    logic            missed_q, missed_d;
    logic            req_q, req_d;
    logic            expire;
    logic            consume;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            timer_q   <= TW'(TREFI - 1);
            wait_q    <= '0;
            pending_q <= 1'b0;
            missed_q  <= 1'b0;
            req_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            wait_q    <= wait_d;
            pending_q <= pending_d;
            missed_q  <= missed_d;
            req_q     <= req_d;
        end
    end

    always_comb begin
        timer_d = timer_q;
        expire  = 1'b0;
        if (enable) begin
            if (timer_q == '0) begin
                expire  = 1'b1;
                timer_d = TW'(TREFI - 1);
            end else begin
                timer_d = timer_q - TW'(1);
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        wait_d          = wait_q;
        consume         = 1'b0;
        cmd_valid       = 1'b0;
        cmd_payload_a   = '0;
        cmd_payload_ras = 1'b0;
        cmd_payload_cas = 1'b0;
        cmd_payload_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    consume = 1'b1;
                    state_d = S_WAIT_GNT;
                end
            end
            S_WAIT_GNT: begin
                if (&refresh_gnt) state_d = S_PRE;
            end
            S_PRE: begin
                cmd_valid       = 1'b1;
                cmd_payload_ras = 1'b1;
                cmd_payload_we  = 1'b1;
                cmd_payload_a   = A_PRE_ALL;
                if (cmd_ready) begin
                    wait_d  = WW'(TRP - 1);
                    state_d = S_WAIT_TRP;
                end
            end
            S_WAIT_TRP: begin
                if (wait_q == '0) state_d = S_REF;
                else              wait_d  = wait_q - WW'(1);
            end
            S_REF: begin
                cmd_valid       = 1'b1;
                cmd_payload_ras = 1'b1;
                cmd_payload_cas = 1'b1;
                if (cmd_ready) begin
                    wait_d  = WW'(TRFC - 1);
                    state_d = S_WAIT_TRFC;
                end
            end
            S_WAIT_TRFC: begin
                if (wait_q == '0) begin
`ifdef REFRESH_ZQCS_EN
                    state_d = S_ZQ;
`else
                    state_d = S_IDLE;
`endif
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
`ifdef REFRESH_ZQCS_EN
            S_ZQ: begin
                cmd_valid      = 1'b1;
                cmd_payload_we = 1'b1;
                if (cmd_ready) begin
                    wait_d  = WW'(TZQCS - 1);
                    state_d = S_WAIT_ZQ;
                end
            end
            S_WAIT_ZQ: begin
                if (wait_q == '0) state_d = S_IDLE;
                else              wait_d  = wait_q - WW'(1);
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // An expiry that lands while a refresh is still owed is lost, not queued.
    assign pending_d = expire | (pending_q & ~consume);
    assign missed_d  = missed_q | (expire & pending_q);
    assign req_d     = (state_d != S_IDLE);

    assign refresh_req          = req_q;
    assign missed               = missed_q;
    assign busy                 = (state_q != S_IDLE);
    assign cmd_payload_ba       = '0;
    assign cmd_payload_is_cmd   = cmd_valid;
    assign cmd_payload_is_read  = 1'b0;
    assign cmd_payload_is_write = 1'b0;
endmodule

// File: tb/tb_refresh_sequencer.sv
// Bench for refresh_sequencer: table-driven basic sequence, hand-written corner cases,
// and randomized traffic compared against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_refresh_sequencer;
    localparam int NB = 8, AW = 14, BW = 3;
    localparam int TREFI = 20, TRP = 3, TRFC = 5, TZQCS = 4;
`ifdef REFRESH_ZQCS_EN
    localparam bit ZQ_EN = 1'b1;
`else
    localparam bit ZQ_EN = 1'b0;
`endif

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          enable = 1'b0;
    logic          refresh_req;
    logic [NB-1:0] refresh_gnt = '1;
    logic          cmd_valid;
    logic          cmd_ready = 1'b1;
    logic [AW-1:0] cmd_payload_a;
    logic [BW-1:0] cmd_payload_ba;
    logic          cmd_payload_cas, cmd_payload_ras, cmd_payload_we;
    logic          cmd_payload_is_cmd, cmd_payload_is_read, cmd_payload_is_write;
    logic          busy, missed;

    refresh_sequencer #(
        .NBANKS(NB), .A_WIDTH(AW), .BA_WIDTH(BW),
        .TREFI(TREFI), .TRP(TRP), .TRFC(TRFC), .TZQCS(TZQCS)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable),
        .refresh_req(refresh_req), .refresh_gnt(refresh_gnt),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_payload_a(cmd_payload_a), .cmd_payload_ba(cmd_payload_ba),
        .cmd_payload_cas(cmd_payload_cas), .cmd_payload_ras(cmd_payload_ras),
        .cmd_payload_we(cmd_payload_we), .cmd_payload_is_cmd(cmd_payload_is_cmd),
        .cmd_payload_is_read(cmd_payload_is_read), .cmd_payload_is_write(cmd_payload_is_write),
        .busy(busy), .missed(missed)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act === want) passes++;
        else $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, want);
    endtask

    function automatic logic [31:0] status();
        return {29'b0, refresh_req, busy, missed};
    endfunction

    function automatic logic [31:0] cmd_bus();
        return {8'b0, cmd_valid, cmd_payload_is_cmd, cmd_payload_ras, cmd_payload_cas,
                cmd_payload_we, cmd_payload_is_read, cmd_payload_is_write, cmd_payload_ba, cmd_payload_a};
    endfunction

    // rcw = {ras, cas, we}
    function automatic logic [31:0] exp_cmd(input logic v, input logic [2:0] rcw, input logic [13:0] a);
        return {8'b0, v, v, rcw, 2'b00, 3'b000, a};
    endfunction

    task automatic step();
        @(posedge sys_clk);
        @(negedge sys_clk);
        cyc++;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        enable = 1'b0;
        cmd_ready = 1'b1;
        refresh_gnt = '1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        cyc = 0;
    endtask

    typedef struct packed {
        int         c;
        logic       en;
        logic       rdy;
        logic [2:0] st;
        logic       v;
        logic [2:0] rcw;
        logic [13:0] a;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input int c, input logic [2:0] st, input logic v, input logic [2:0] rcw, input logic [13:0] a);
        vec_t e;
        e.c = c; e.en = 1'b1; e.rdy = 1'b1; e.st = st; e.v = v; e.rcw = rcw; e.a = a;
        tbl.push_back(e);
    endtask

    // Reference model: enabled-cycle count since last expiry, phase, and elapsed cycles in a gap.
    localparam int P_IDLE = 0, P_REQ = 1, P_PRE = 2, P_GAP_RP = 3, P_REF = 4, P_GAP_RFC = 5, P_ZQ = 6, P_GAP_ZQ = 7;
    int m_cnt, m_ph, m_el;
    bit m_pend, m_miss;

    task automatic model_step();
        bit fired, pend_old;
        pend_old = m_pend;
        fired = 1'b0;
        if (enable) begin
            m_cnt++;
            if (m_cnt == TREFI) begin fired = 1'b1; m_cnt = 0; end
        end
        case (m_ph)
            P_IDLE:    if (m_pend) begin m_ph = P_REQ; m_pend = 1'b0; end
            P_REQ:     if (refresh_gnt == {NB{1'b1}}) m_ph = P_PRE;
            P_PRE:     if (cmd_ready) begin m_ph = P_GAP_RP; m_el = 0; end
            P_GAP_RP:  begin m_el++; if (m_el == TRP) m_ph = P_REF; end
            P_REF:     if (cmd_ready) begin m_ph = P_GAP_RFC; m_el = 0; end
            P_GAP_RFC: begin m_el++; if (m_el == TRFC) m_ph = ZQ_EN ? P_ZQ : P_IDLE; end
            P_ZQ:      if (cmd_ready) begin m_ph = P_GAP_ZQ; m_el = 0; end
            P_GAP_ZQ:  begin m_el++; if (m_el == TZQCS) m_ph = P_IDLE; end
            default:   m_ph = P_IDLE;
        endcase
        if (fired && pend_old) m_miss = 1'b1;
        if (fired) m_pend = 1'b1;
    endtask

    function automatic logic [31:0] model_cmd();
        case (m_ph)
            P_PRE:   return exp_cmd(1'b1, 3'b101, 14'h400);
            P_REF:   return exp_cmd(1'b1, 3'b110, 14'h000);
            P_ZQ:    return exp_cmd(1'b1, 3'b001, 14'h000);
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        int end_cyc;

        // Basic sequence table
        add(0,  3'b000, 1'b0, 3'b000, 14'h000);
        add(19, 3'b000, 1'b0, 3'b000, 14'h000);
        add(20, 3'b000, 1'b0, 3'b000, 14'h000);
        add(21, 3'b110, 1'b0, 3'b000, 14'h000);
        add(22, 3'b110, 1'b1, 3'b101, 14'h400);
        add(23, 3'b110, 1'b0, 3'b000, 14'h000);
        add(25, 3'b110, 1'b0, 3'b000, 14'h000);
        add(26, 3'b110, 1'b1, 3'b110, 14'h000);
        add(27, 3'b110, 1'b0, 3'b000, 14'h000);
        add(31, 3'b110, 1'b0, 3'b000, 14'h000);
`ifdef REFRESH_ZQCS_EN
        add(32, 3'b110, 1'b1, 3'b001, 14'h000);
        add(33, 3'b110, 1'b0, 3'b000, 14'h000);
        add(36, 3'b110, 1'b0, 3'b000, 14'h000);
        add(37, 3'b000, 1'b0, 3'b000, 14'h000);
`else
        add(32, 3'b000, 1'b0, 3'b000, 14'h000);
        add(33, 3'b000, 1'b0, 3'b000, 14'h000);
`endif
        add(40, 3'b000, 1'b0, 3'b000, 14'h000);
        add(41, 3'b110, 1'b0, 3'b000, 14'h000);
        add(42, 3'b110, 1'b1, 3'b101, 14'h400);

        do_reset();
        foreach (tbl[i]) begin
            while (cyc < tbl[i].c) step();
            enable = tbl[i].en;
            cmd_ready = tbl[i].rdy;
            #1;
            check("basic_status", status(), {29'b0, tbl[i].st});
            check("basic_cmd", cmd_bus(), exp_cmd(tbl[i].v, tbl[i].rcw, tbl[i].a));
        end

        // Grant gating: bank 5 low for 10 cycles after refresh_req rises
        do_reset();
        enable = 1'b1;
        refresh_gnt = 8'hDF;
        while (cyc < 21) step();
        #1 check("gnt_req_rise", status(), 32'b110);
        for (int c = 21; c <= 31; c++) begin
            if (c == 31) refresh_gnt = '1;
            #1 check("gnt_hold_valid", cmd_bus(), 32'h0);
            step();
        end
        #1 check("gnt_pre", cmd_bus(), exp_cmd(1'b1, 3'b101, 14'h400));

        // Back-pressure on PRE for 7 cycles
        do_reset();
        enable = 1'b1;
        while (cyc < 22) step();
        for (int c = 22; c <= 29; c++) begin
            cmd_ready = (c == 29);
            #1 check("bp_pre_hold", cmd_bus(), exp_cmd(1'b1, 3'b101, 14'h400));
            step();
        end
        for (int c = 30; c <= 32; c++) begin
            #1 check("bp_trp_gap", cmd_bus(), 32'h0);
            step();
        end
        #1 check("bp_ref", cmd_bus(), exp_cmd(1'b1, 3'b110, 14'h000));

        // Overrun: grants low for 45 cycles after the request
        do_reset();
        enable = 1'b1;
        refresh_gnt = '0;
        while (cyc < 59) step();
        #1 check("ovr_missed_clear", status(), 32'b110);
        step();
        #1 check("ovr_missed_set", status(), 32'b111);
        while (cyc < 66) step();
        refresh_gnt = '1;
        #1 check("ovr_no_cmd", cmd_bus(), 32'h0);
        step();
        #1 check("ovr_pre", cmd_bus(), exp_cmd(1'b1, 3'b101, 14'h400));
        end_cyc = ZQ_EN ? 82 : 77;
        while (cyc < end_cyc) step();
        #1 check("ovr_idle", status(), 32'b001);
        step();
        #1 check("ovr_pending_rerun", status(), 32'b111);

        // Asynchronous reset during WAIT_TRFC
        do_reset();
        enable = 1'b1;
        while (cyc < 28) step();
        #1 check("rst_before", status(), 32'b110);
        #1 sys_rst = 1'b1;
        #1;
        check("rst_async_status", status(), 32'h0);
        check("rst_async_cmd", cmd_bus(), 32'h0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        cyc = 0;
        while (cyc < 20) step();
        #1 check("rst_no_early_req", status(), 32'b000);
        step();
        #1 check("rst_first_req", status(), 32'b110);

        // Randomized traffic against the reference model
        do_reset();
        m_cnt = 0; m_ph = P_IDLE; m_el = 0; m_pend = 1'b0; m_miss = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            enable = ($urandom_range(0, 99) < 85);
            cmd_ready = ($urandom_range(0, 99) < 65);
            refresh_gnt = ($urandom_range(0, 99) < 60) ? {NB{1'b1}} : NB'($urandom);
            #1;
            check("rand_status", status(), {29'b0, (m_ph != P_IDLE), (m_ph != P_IDLE), m_miss});
            check("rand_cmd", cmd_bus(), model_cmd());
            model_step();
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
